ir_packet_tx: RTL and testbench

Parametrised successor to the single-car IR transmitter state machine. It sends one IR command packet: START burst, GAP, SELECT burst, GAP, then one ASSERT or DE-ASSERT burst per command bit (MSB first), each followed by a GAP.
- Four car profiles (carrier frequency and burst lengths) are selectable per packet.
- Command width is parametrised.
- Adds a proper request/busy/done handshake and a one-deep pending request buffer.
- Sits between the bus-side command register and the IR LED pin.

---
 rtl/ir_packet_tx_pkg.sv | 52 +++++
 rtl/ir_packet_tx_if.sv | 21 ++
 rtl/ir_carrier_gen.sv | 48 ++++
 rtl/ir_packet_tx.sv | 195 +++++++++++++++++++
 tb/tb_ir_packet_tx.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ir_packet_tx_pkg.sv
// Shared types and car profile table for the IR packet transmitter.
// Package name is ir_tx_pkg; the optional parity bit is enabled by IR_TX_PARITY_EN.
package ir_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_GAP      = 3'd2,
    ST_SELECT   = 3'd3,
    ST_ASSERT   = 3'd4,
    ST_DEASSERT = 3'd5
  } state_e;

  // Lengths are in carrier periods; half_period is in clock cycles.
  typedef struct packed {
    logic [10:0] half_period;
    logic [7:0]  start_len;
    logic [7:0]  gap_len;
    logic [7:0]  select_len;
    logic [7:0]  assert_len;
    logic [7:0]  deassert_len;
  } profile_t;

  localparam logic [1:0] CAR_BLUE   = 2'd0;
  localparam logic [1:0] CAR_YELLOW = 2'd1;
  localparam logic [1:0] CAR_GREEN  = 2'd2;
  localparam logic [1:0] CAR_RED    = 2'd3;

  localparam int NUM_CARS        = 4;
  localparam int MAX_HALF_PERIOD = 1389;

  localparam profile_t PROFILES [NUM_CARS] = '{
    '{11'd1389, 8'd191, 8'd25, 8'd47, 8'd47, 8'd22},
    '{11'd1250, 8'd88,  8'd40, 8'd22, 8'd44, 8'd22},
    '{11'd1333, 8'd88,  8'd40, 8'd44, 8'd44, 8'd22},
    '{11'd1250, 8'd192, 8'd24, 8'd24, 8'd48, 8'd24}
  };

  // The default entry only matters once the select grows beyond four cars.
  function automatic profile_t car_profile(input logic [1:0] sel, input logic [1:0] dflt);
    profile_t p;
    case (sel)
      CAR_BLUE:   p = PROFILES[CAR_BLUE];
      CAR_YELLOW: p = PROFILES[CAR_YELLOW];
      CAR_GREEN:  p = PROFILES[CAR_GREEN];
      CAR_RED:    p = PROFILES[CAR_RED];
      default:    p = PROFILES[dflt];
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ir_packet_tx_if.sv
// Request/status bundle between the command register side and the IR transmitter.
interface ir_packet_tx_if #(parameter int CMD_WIDTH = 4);
  logic                 SEND_PACKET;
  logic [CMD_WIDTH-1:0] COMMAND;
  logic [1:0]           CAR_SEL;
  logic                 IR_LED;
  logic                 BUSY;
  logic                 DONE;
  logic                 PENDING;
  logic [2:0]           CURR_STATE;

  modport master (
    output SEND_PACKET, COMMAND, CAR_SEL,
    input  IR_LED, BUSY, DONE, PENDING, CURR_STATE
  );

  modport slave (
    input  SEND_PACKET, COMMAND, CAR_SEL,
    output IR_LED, BUSY, DONE, PENDING, CURR_STATE
  );
endinterface

// File: rtl/ir_carrier_gen.sv
// Carrier timebase: square wave of period 2*half_period starting low, plus a
// one-cycle strobe on the last cycle of each full period.
module ir_carrier_gen #(
  parameter int HP_W = 11
) (
  input  logic            clk_sys,
  input  logic            rst_b,
  input  logic [HP_W-1:0] half_period,
  input  logic            enable,
  input  logic            restart,
  output logic            carrier,
  output logic            period_done
);

  logic [HP_W-1:0] hp_cnt_q, hp_cnt_d;
  logic            level_q, level_d;
  logic            hp_tc;

  assign hp_tc = (hp_cnt_q == (half_period - HP_W'(1)));

  always_comb begin
    hp_cnt_d = hp_cnt_q;
    level_d  = level_q;
    if (!enable || restart) begin
      hp_cnt_d = '0;
      level_d  = 1'b0;
    end else if (hp_tc) begin
      hp_cnt_d = '0;
      level_d  = ~level_q;
    end else begin
      hp_cnt_d = hp_cnt_q + HP_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      hp_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      hp_cnt_q <= hp_cnt_d;
      level_q  <= level_d;
    end
  end

  assign carrier     = level_q;
  assign period_done = enable && level_q && hp_tc;

endmodule

// File: rtl/ir_packet_tx.sv
// IR command packet transmitter: START, GAP, SELECT, GAP, then one data burst
// plus gap per bit. Define IR_TX_PARITY_EN to append an even-parity data bit.
module ir_packet_tx
  import ir_tx_pkg::*;
#(
  parameter int CMD_WIDTH            = 4,
  parameter int HALF_PERIOD_OVERRIDE = 0,
  parameter int DEFAULT_CAR          = 0
) (
  input logic          CLK,
  input logic          RESETN,
  ir_packet_tx_if.slave bus
);

`ifdef IR_TX_PARITY_EN
  localparam int NBITS = CMD_WIDTH + 1;
`else
  localparam int NBITS = CMD_WIDTH;
`endif
  localparam int MAX_HP = (HALF_PERIOD_OVERRIDE > MAX_HALF_PERIOD) ? HALF_PERIOD_OVERRIDE
                                                                    : MAX_HALF_PERIOD;
  localparam int HP_W = $clog2(MAX_HP + 1);
  localparam int BC_W = $clog2(NBITS + 1);
  localparam logic [BC_W-1:0] NBITS_C  = BC_W'(NBITS);
  localparam logic [1:0]      DFLT_SEL = DEFAULT_CAR[1:0];

  function automatic logic [NBITS-1:0] load_bits(input logic [CMD_WIDTH-1:0] cmd);
`ifdef IR_TX_PARITY_EN
    return {cmd, ^cmd};
`else
    return cmd;
`endif
  endfunction

  state_e               state_q, state_d;
  logic [NBITS-1:0]     shift_q, shift_d;
  logic [1:0]           car_q, car_d;
  logic [CMD_WIDTH-1:0] pbuf_cmd_q, pbuf_cmd_d;
  logic [1:0]           pbuf_car_q, pbuf_car_d;
  logic                 pend_q, pend_d;
  logic [7:0]           per_cnt_q, per_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 sel_done_q, sel_done_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 burst_q, burst_d;

  profile_t        prof;
  logic [HP_W-1:0] half_period;
  logic [7:0]      phase_len;
  logic            carrier;
  logic            period_done;
  logic            phase_end;

  assign prof        = car_profile(car_q, DFLT_SEL);
  assign half_period = (HALF_PERIOD_OVERRIDE != 0) ? HP_W'(HALF_PERIOD_OVERRIDE)
                                                   : HP_W'(prof.half_period);

  always_comb begin
    case (state_q)
      ST_START:    phase_len = prof.start_len;
      ST_GAP:      phase_len = prof.gap_len;
      ST_SELECT:   phase_len = prof.select_len;
      ST_ASSERT:   phase_len = prof.assert_len;
      ST_DEASSERT: phase_len = prof.deassert_len;
      default:     phase_len = 8'd0;
    endcase
  end

  assign phase_end = period_done && ((per_cnt_q + 8'd1) == phase_len);

  // The timebase also runs through gaps so they are measured in carrier periods;
  // only the pin is gated outside bursts.
  ir_carrier_gen #(.HP_W(HP_W)) u_carrier (
    .clk_sys     (CLK),
    .rst_b       (RESETN),
    .half_period (half_period),
    .enable      (busy_q),
    .restart     (phase_end),
    .carrier     (carrier),
    .period_done (period_done)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    car_d      = car_q;
    pbuf_cmd_d = pbuf_cmd_q;
    pbuf_car_d = pbuf_car_q;
    pend_d     = pend_q;
    per_cnt_d  = per_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sel_done_d = sel_done_q;
    done_d     = 1'b0;

    if (state_q != ST_IDLE && bus.SEND_PACKET) begin
      pend_d     = 1'b1;
      pbuf_cmd_d = bus.COMMAND;
      pbuf_car_d = bus.CAR_SEL;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q || bus.SEND_PACKET) begin
          state_d    = ST_START;
          per_cnt_d  = '0;
          bit_cnt_d  = '0;
          sel_done_d = 1'b0;
          if (pend_q) begin
            // Buffered request wins; a fresh strobe in the same cycle queues behind it.
            shift_d = load_bits(pbuf_cmd_q);
            car_d   = pbuf_car_q;
            pend_d  = bus.SEND_PACKET;
            if (bus.SEND_PACKET) begin
              pbuf_cmd_d = bus.COMMAND;
              pbuf_car_d = bus.CAR_SEL;
            end
          end else begin
            shift_d = load_bits(bus.COMMAND);
            car_d   = bus.CAR_SEL;
          end
        end
      end
      default: begin
        if (phase_end) begin
          per_cnt_d = '0;
          case (state_q)
            ST_GAP: begin
              if (!sel_done_q) begin
                state_d = ST_SELECT;
              end else if (bit_cnt_q < NBITS_C) begin
                state_d = shift_q[NBITS-1] ? ST_ASSERT : ST_DEASSERT;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
            ST_SELECT: begin
              sel_done_d = 1'b1;
              state_d    = ST_GAP;
            end
            ST_ASSERT, ST_DEASSERT: begin
              shift_d   = shift_q << 1;
              bit_cnt_d = bit_cnt_q + BC_W'(1);
              state_d   = ST_GAP;
            end
            default: state_d = ST_GAP;
          endcase
        end else if (period_done) begin
          per_cnt_d = per_cnt_q + 8'd1;
        end
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    burst_d = state_d inside {ST_START, ST_SELECT, ST_ASSERT, ST_DEASSERT};
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      car_q      <= '0;
      pbuf_cmd_q <= '0;
      pbuf_car_q <= '0;
      pend_q     <= 1'b0;
      per_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sel_done_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      burst_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      car_q      <= car_d;
      pbuf_cmd_q <= pbuf_cmd_d;
      pbuf_car_q <= pbuf_car_d;
      pend_q     <= pend_d;
      per_cnt_q  <= per_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sel_done_q <= sel_done_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      burst_q    <= burst_d;
    end
  end

  assign bus.IR_LED     = carrier & burst_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.PENDING    = pend_q;
  assign bus.CURR_STATE = state_q;

endmodule

// File: tb/tb_ir_packet_tx.sv
// Directed bench for ir_packet_tx with a 4-cycle carrier half-period; records every
// phase (state, length, carrier rises) and compares against the profile table.
module tb_ir_packet_tx;

  localparam int HP  = 4;
  localparam int PER = 2 * HP;
  localparam int S_IDLE = 0, S_START = 1, S_GAP = 2, S_SELECT = 3, S_ASSERT = 4, S_DEASSERT = 5;
`ifdef IR_TX_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  typedef struct {
    int st;
    int len;
    int rises;
  } phase_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ir_packet_tx_if #(.CMD_WIDTH(4)) bus();

  ir_packet_tx #(
    .CMD_WIDTH            (4),
    .HALF_PERIOD_OVERRIDE (HP),
    .DEFAULT_CAR          (0)
  ) dut (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // start, gap, select, assert, deassert (carrier periods)
  int prof_tab [4][5] = '{'{191, 25, 47, 47, 22},
                          '{ 88, 40, 22, 44, 22},
                          '{ 88, 40, 44, 44, 22},
                          '{192, 24, 24, 48, 24}};

  phase_t exp_q[$];
  phase_t got_q[$];

  task automatic chk_val(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_exp(input int st, input int n);
    phase_t p;
    p.st    = st;
    p.len   = n * PER;
    p.rises = (st == S_GAP) ? 0 : n;
    exp_q.push_back(p);
  endtask

  task automatic build_exp(input int car, input logic [3:0] cmd);
    logic [4:0] bits;
    logic       b;
    exp_q.delete();
    add_exp(S_START, prof_tab[car][0]);
    add_exp(S_GAP, prof_tab[car][1]);
    add_exp(S_SELECT, prof_tab[car][2]);
    add_exp(S_GAP, prof_tab[car][1]);
    bits = {cmd, 1'b0};
`ifdef IR_TX_PARITY_EN
    bits[0] = ^cmd;
`endif
    for (int i = 0; i < NB; i++) begin
      b = bits[4-i];
      if (b) add_exp(S_ASSERT, prof_tab[car][3]);
      else   add_exp(S_DEASSERT, prof_tab[car][4]);
      add_exp(S_GAP, prof_tab[car][1]);
    end
  endtask

  // Call on the negedge of the first busy cycle; returns on the first idle negedge.
  task automatic watch_pkt(output int busy_cyc);
    phase_t p;
    int     prev_led;
    got_q.delete();
    busy_cyc = 0;
    prev_led = 0;
    p.st     = int'(bus.CURR_STATE);
    p.len    = 0;
    p.rises  = 0;
    while (bus.BUSY === 1'b1 && busy_cyc < 20000) begin
      if (int'(bus.CURR_STATE) != p.st) begin
        got_q.push_back(p);
        p.st    = int'(bus.CURR_STATE);
        p.len   = 0;
        p.rises = 0;
      end
      p.len++;
      if (bus.IR_LED === 1'b1 && prev_led == 0) p.rises++;
      prev_led = (bus.IR_LED === 1'b1) ? 1 : 0;
      busy_cyc++;
      @(negedge clk);
    end
    got_q.push_back(p);
    if (busy_cyc >= 20000) chk_val("busy_timeout", busy_cyc, 0);
  endtask

  task automatic cmp_phases(input string tag);
    chk_val({tag, ".nphases"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk_val($sformatf("%s.ph%0d.state", tag, i), got_q[i].st, exp_q[i].st);
      chk_val($sformatf("%s.ph%0d.len", tag, i), got_q[i].len, exp_q[i].len);
      chk_val($sformatf("%s.ph%0d.rises", tag, i), got_q[i].rises, exp_q[i].rises);
    end
  endtask

  task automatic pulse_req(input logic [3:0] cmd, input logic [1:0] car);
    @(posedge clk);
    #2;
    bus.SEND_PACKET = 1'b1;
    bus.COMMAND     = cmd;
    bus.CAR_SEL     = car;
    @(posedge clk);
    #2;
    bus.SEND_PACKET = 1'b0;
  endtask

  initial begin
    int bc;
    int asserts;
    int prev_st;
    int cur_st;
    int cyc;
    int hit;
    int data_bursts;

    bus.SEND_PACKET = 1'b0;
    bus.COMMAND     = 4'b0000;
    bus.CAR_SEL     = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_val("rst.led", bus.IR_LED, 0);
    chk_val("rst.busy", bus.BUSY, 0);
    chk_val("rst.done", bus.DONE, 0);
    chk_val("rst.pending", bus.PENDING, 0);
    chk_val("rst.state", bus.CURR_STATE, S_IDLE);

    // Blue, 1010
    pulse_req(4'b1010, 2'd0);
    @(negedge clk);
    chk_val("t1.launch_state", bus.CURR_STATE, S_START);
    watch_pkt(bc);
`ifdef IR_TX_PARITY_EN
    chk_val("t1.busy_cycles", bc, 4208 + 47 * 8);
`else
    chk_val("t1.busy_cycles", bc, 4208);
`endif
    build_exp(0, 4'b1010);
    cmp_phases("t1");
    chk_val("t1.done", bus.DONE, 1);
    chk_val("t1.pending", bus.PENDING, 0);
    @(negedge clk);
    chk_val("t1.done_one_cycle", bus.DONE, 0);
    chk_val("t1.idle", bus.BUSY, 0);

    // Yellow, 0000
    repeat (5) @(negedge clk);
    pulse_req(4'b0000, 2'd1);
    @(negedge clk);
    watch_pkt(bc);
`ifdef IR_TX_PARITY_EN
    chk_val("t2.busy_cycles", bc, (88 + 40 + 22 + 5 * (22 + 40) + 40) * 8);
`else
    chk_val("t2.busy_cycles", bc, (88 + 40 + 22 + 4 * (22 + 40) + 40) * 8);
`endif
    build_exp(1, 4'b0000);
    cmp_phases("t2");
    chk_val("t2.done", bus.DONE, 1);
    @(negedge clk);
    chk_val("t2.done_one_cycle", bus.DONE, 0);

    // Green 0110, red 1111 queued during START
    repeat (5) @(negedge clk);
    pulse_req(4'b0110, 2'd2);
    @(negedge clk);
    fork
      watch_pkt(bc);
      begin
        repeat (100) @(posedge clk);
        pulse_req(4'b1111, 2'd3);
        chk_val("t3.pend_set", bus.PENDING, 1);
        chk_val("t3.in_start", bus.CURR_STATE, S_START);
      end
    join
    build_exp(2, 4'b0110);
    cmp_phases("t3a");
    chk_val("t3a.done", bus.DONE, 1);
    chk_val("t3a.pend_held", bus.PENDING, 1);
    chk_val("t3a.idle_state", bus.CURR_STATE, S_IDLE);
    @(negedge clk);
    chk_val("t3b.relaunch", bus.CURR_STATE, S_START);
    chk_val("t3b.pend_clear", bus.PENDING, 0);
    chk_val("t3b.done_low", bus.DONE, 0);
    watch_pkt(bc);
    build_exp(3, 4'b1111);
    cmp_phases("t3b");
    chk_val("t3b.done", bus.DONE, 1);
    @(negedge clk);
    chk_val("t3b.idle", bus.BUSY, 0);

    // Blue 0001 with three queued requests; only red 0101 must follow
    repeat (5) @(negedge clk);
    pulse_req(4'b0001, 2'd0);
    @(negedge clk);
    fork
      watch_pkt(bc);
      begin
        repeat (100) @(posedge clk);
        pulse_req(4'b1100, 2'd1);
        chk_val("t4.pend1", bus.PENDING, 1);
        repeat (1400) @(posedge clk);
        pulse_req(4'b0011, 2'd2);
        chk_val("t4.pend2", bus.PENDING, 1);
        repeat (1500) @(posedge clk);
        pulse_req(4'b0101, 2'd3);
        chk_val("t4.pend3", bus.PENDING, 1);
      end
    join
    build_exp(0, 4'b0001);
    cmp_phases("t4a");
    chk_val("t4a.done", bus.DONE, 1);
    chk_val("t4a.pend_held", bus.PENDING, 1);
    @(negedge clk);
    chk_val("t4b.pend_clear", bus.PENDING, 0);
    watch_pkt(bc);
    build_exp(3, 4'b0101);
    cmp_phases("t4b");
    repeat (20) @(negedge clk);
    chk_val("t4.no_third", bus.BUSY, 0);

    // Reset during the second ASSERT burst, with a request pending
    pulse_req(4'b1010, 2'd0);
    repeat (10) @(posedge clk);
    pulse_req(4'b0000, 2'd1);
    asserts = 0;
    prev_st = S_START;
    cyc     = 0;
    hit     = 0;
    while (hit == 0 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      cur_st = int'(bus.CURR_STATE);
      if (cur_st == S_ASSERT && prev_st != S_ASSERT) asserts++;
      if (asserts == 2 && cur_st == S_ASSERT && bus.IR_LED === 1'b1) hit = 1;
      prev_st = cur_st;
    end
    chk_val("t5.reached_assert2", hit, 1);
    chk_val("t5.pend_before", bus.PENDING, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("t5.led", bus.IR_LED, 0);
    chk_val("t5.busy", bus.BUSY, 0);
    chk_val("t5.pending", bus.PENDING, 0);
    chk_val("t5.state", bus.CURR_STATE, S_IDLE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk_val("t5.stay_idle", bus.BUSY, 0);
    chk_val("t5.stay_state", bus.CURR_STATE, S_IDLE);

    // Blue 1011: parity bit (1) appended only when the option is built in
    pulse_req(4'b1011, 2'd0);
    @(negedge clk);
    watch_pkt(bc);
    build_exp(0, 4'b1011);
    cmp_phases("t6");
    data_bursts = 0;
    foreach (got_q[i]) if (got_q[i].st == S_ASSERT || got_q[i].st == S_DEASSERT) data_bursts++;
    chk_val("t6.data_bursts", data_bursts, NB);
    chk_val("t6.done", bus.DONE, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
